// File: rtl/moving_avg_filter_if.sv
// moving_avg_filter_if: valid/ready stream bundle (input side, output side, flush) for one filter channel.
interface moving_avg_filter_if #(parameter int DATA_W = 24);
    logic                     clear;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    modport master(output clear, in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave(input clear, in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/moving_avg_filter.sv
// moving_avg_filter: N-tap boxcar average over a circular buffer with a running-sum accumulator.
// Define MOVING_AVG_ROUND_EN for round-half-up output instead of floor.
module moving_avg_filter #(
    parameter int DATA_W = 24,
    parameter int LOG2_N = 3
) (
    input logic               clk,
    input logic               reset,
    moving_avg_filter_if.slave bus
);
    localparam int N     = 2 ** LOG2_N;
    localparam int ACC_W = DATA_W + LOG2_N;
    typedef enum logic {FILL, RUN} state_t;
    state_t                   r_state, w_state_next;
    logic signed [DATA_W-1:0] r_buf [N];
    logic [LOG2_N-1:0]        r_wptr;
    logic [LOG2_N:0]          r_count;
    logic signed [ACC_W-1:0]  r_acc, w_acc_next;
    logic signed [DATA_W-1:0] w_oldest, w_result, r_out_data;
    logic                     r_out_valid, w_accept;
    assign bus.in_ready  = !bus.clear && (!r_out_valid || bus.out_ready);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign w_accept      = bus.in_valid && bus.in_ready;
    // Buffer entries are only read in RUN, i.e. after every slot has been written.
    assign w_oldest   = (r_state == RUN) ? r_buf[r_wptr] : '0;
    assign w_acc_next = r_acc + ACC_W'(bus.in_data) - ACC_W'(w_oldest);
`ifdef MOVING_AVG_ROUND_EN
    logic signed [ACC_W:0] w_rounded;
    assign w_rounded = {w_acc_next[ACC_W-1], w_acc_next} + (ACC_W+1)'(N / 2);
    assign w_result  = DATA_W'(w_rounded >>> LOG2_N);
`else
    assign w_result  = DATA_W'(w_acc_next >>> LOG2_N);
`endif
    always_comb begin
        w_state_next = r_state;
        if (bus.clear)
            w_state_next = FILL;
        else if (w_accept && r_state == FILL && r_count == (LOG2_N+1)'(N - 1))
            w_state_next = RUN;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= FILL;
        else       r_state <= w_state_next;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (bus.clear) begin
            r_acc       <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_acc       <= w_acc_next;
            r_wptr      <= r_wptr + 1'b1;
            r_count     <= (r_state == FILL) ? r_count + 1'b1 : r_count;
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
    always_ff @(posedge clk)
        if (w_accept) r_buf[r_wptr] <= bus.in_data;
endmodule
